// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over WIDTH cycles, with stall generation for dependent instructions.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] negw(input logic [WIDTH-1:0] v);
        negw = ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2(input logic [2*WIDTH-1:0] v);
        neg2 = ~v + (2*WIDTH)'(1);
    endfunction

    function automatic logic [WIDTH-1:0] absw(input logic signed [WIDTH-1:0] v,
                                              input logic sgn);
        absw = (sgn && (v < 0)) ? negw(v) : v;
    endfunction

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              is_div, neg_q, neg_r, b_zero;
    logic [WIDTH-1:0]  opnd, acc_hi, acc_lo, a_raw;

    logic              sgn_in;
    logic [WIDTH-1:0]  ma, mb, addend, quo, rem;
    logic [WIDTH:0]    sum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod;
    logic              accept;

    assign busy   = (state != IDLE);
    assign stall  = busy & (start | rd_req | wr_hi | wr_lo);
    assign accept = (state == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (abort)                        state_nxt = IDLE;
                else if (cnt == CW'(WIDTH - 1))   state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand conditioning, one iteration step and final sign correction
    always_comb begin
        sgn_in = ~op[0];
        ma     = absw(a, sgn_in);
        mb     = absw(b, sgn_in);
        addend = acc_lo[0] ? opnd : '0;
        sum    = {1'b0, acc_hi} + {1'b0, addend};
        rem_sh = {acc_hi, acc_lo[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd};
        prod   = {acc_hi, acc_lo};
        if (neg_q) prod = neg2(prod);
        quo    = neg_q ? negw(acc_lo) : acc_lo;
        rem    = neg_r ? negw(acc_hi) : acc_hi;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            a_raw    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (accept) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_q  <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= sgn_in & a[WIDTH-1];
                        b_zero <= (b == '0);
                        a_raw  <= a;
                        acc_hi <= '0;
                        opnd   <= op[1] ? mb : ma;
                        acc_lo <= op[1] ? ma : mb;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        if (!diff[WIDTH]) begin
                            acc_hi <= diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= rem_sh[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= sum[WIDTH:1];
                        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!abort) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end else if (b_zero) begin
                            // Divide by zero reports all-ones quotient, raw dividend remainder
                            hi       <= a_raw;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, stall, abort, mthi/mtlo and reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, rd_req, wr_hi, wr_lo, abort;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero, stall;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .rd_req(rd_req), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .abort(abort),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int bcyc, output int scnt, output logic got,
                         output logic dz, output logic dn_next);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        bcyc = 0; scnt = 0; got = 1'b0; dz = 1'b0; dn_next = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                dz  = div_zero;
                break;
            end
            if (busy)  bcyc++;
            if (stall) scnt++;
        end
        @(negedge clk);
        dn_next = done;
    endtask

    task automatic run_check(input string tag, input logic [1:0] o,
                             input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input logic exp_dz);
        int bcyc, scnt;
        logic got, dz, dn_next;
        do_op(o, x, y, bcyc, scnt, got, dz, dn_next);
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_busy_cycles"}, 64'(bcyc), 64'd33);
        check({tag, "_done_one_cycle"}, 64'(dn_next), 64'd0);
        check({tag, "_stall_quiet"}, 64'(scnt), 64'd0);
        check({tag, "_div_zero"}, 64'(dz), 64'(exp_dz));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        logic got;
        int   stall_bad;

        reset_n = 1'b0;
        start = 0; rd_req = 0; wr_hi = 0; wr_lo = 0; abort = 0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        reset_n = 1'b1;

        run_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_check("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_check("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_check("divu_100",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run_check("divu_zero", 2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_check("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_check("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

        // rd_req during an op stalls every busy cycle; a mid-op mtlo is dropped
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd_req = 1'b1; got = 1'b0; stall_bad = 0;
        for (int i = 0; i < 60; i++) begin
            wr_lo = (i == 3); wdata = 32'hDEAD_BEEF;
            #1;
            if (done) begin
                got = 1'b1;
                check("stall_done_cycle", 64'(stall), 64'd0);
                break;
            end
            if (!stall) stall_bad++;
            if (i == 4) check("mtlo_ignored", 64'(lo), 64'd0);
            @(negedge clk);
        end
        rd_req = 1'b0; wr_lo = 1'b0;
        check("stall_done_seen", 64'(got), 64'd1);
        check("stall_every_busy", 64'(stall_bad), 64'd0);
        check("stall_op_lo", 64'(lo), 64'd30);
        check("stall_op_hi", 64'(hi), 64'd0);

        // abort at cycle 10 of a divide
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy_drop", 64'(busy), 64'd0);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("abort_no_done", 64'(got), 64'd0);
        check("abort_hi_kept", 64'(hi), 64'd0);
        check("abort_lo_kept", 64'(lo), 64'd30);

        // abort together with start in IDLE is not accepted
        @(negedge clk);
        start = 1'b1; abort = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_rejected", 64'(busy), 64'd0);

        run_check("after_abort", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // mthi in IDLE
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        wr_hi = 1'b0;
        check("mthi_idle", 64'(hi), 64'hA5A5_A5A5);
        check("mthi_lo_kept", 64'(lo), 64'd14);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_hi", 64'(hi), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_reset_idle_lo", 64'(lo), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
